// File: rtl/fetch_queue.sv
// Instruction fetch stage: streams words from synchronous imem into a small
// {word, pc} FIFO whose head feeds decode; handles redirect, halt and stalls.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_WORD = 16'h0201,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [15:0]   imem_addr,
  input  logic [15:0]   imem_data,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  input  logic          halt,
  input  logic          deq,
  output logic [15:0]   ir,
  output logic [15:0]   ir_pc,
  output logic          ir_valid,
  output logic [CW-1:0] count
);

  logic [15:0]   word_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];

  logic [15:0]   fpc_q, fpc_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_pc_q, pend_pc_d;
  logic          kill_q, kill_d;

  logic          req;
  logic          wr;
  logic          rd;
  logic [CW-1:0] credit;

  // Credits include the in-flight word so the FIFO can never overflow.
  assign credit = count_q + CW'(pend_q);
  assign req    = reset && !halt && !redirect && (credit < CW'(DEPTH));
  assign wr     = pend_q && !kill_q && !redirect;
  assign rd     = deq && (count_q != '0) && !redirect;

  always_comb begin
    fpc_d     = fpc_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    kill_d    = 1'b0;
    if (redirect) begin
      fpc_d   = redirect_pc;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      kill_d  = pend_q;
    end else begin
      rptr_d  = rptr_q + AW'(rd);
      wptr_d  = wptr_q + AW'(wr);
      count_d = count_q + CW'(wr) - CW'(rd);
      if (req) begin
        fpc_d     = fpc_q + 16'd1;
        pend_d    = 1'b1;
        pend_pc_d = fpc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      kill_q    <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      kill_q    <= kill_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      word_q[wptr_q] <= imem_data;
      pc_q[wptr_q]   <= pend_pc_q;
    end
  end

  assign imem_req  = req;
  assign imem_addr = fpc_q;
  assign ir_valid  = (count_q != '0);
  assign ir        = ir_valid ? word_q[rptr_q] : NOP_WORD;
  assign ir_pc     = ir_valid ? pc_q[rptr_q] : 16'h0000;
  assign count     = count_q;

endmodule
